// File: rtl/mmio_bus.sv
// MMIO interconnect: decodes cpu byte accesses onto word-wide device slots,
// merging sub-word stores by read-modify-write. Hosts the board LED register.
module mmio_bus #(
    parameter int          DEVICE_COUNT = 6,
    parameter logic [31:0] LED_BASE     = 32'hA000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        re,
    input  logic        we,
    input  logic [1:0]  rd_unit,
    input  logic [1:0]  wd_unit,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        access_fault,
    output logic        addr_misaligned,
    output logic [7:0]  led,
    input  logic [31:0] dev_addr_start [DEVICE_COUNT],
    input  logic [31:0] dev_addr_end   [DEVICE_COUNT],
    input  logic        dev_rw         [DEVICE_COUNT],
    output logic [29:0] dev_addr       [DEVICE_COUNT],
    output logic        dev_re         [DEVICE_COUNT],
    input  logic [31:0] dev_rd         [DEVICE_COUNT],
    output logic        dev_we         [DEVICE_COUNT],
    output logic [31:0] dev_wd         [DEVICE_COUNT]
);

    localparam logic [1:0] UNIT_BYTE = 2'd0;
    localparam logic [1:0] UNIT_HALF = 2'd1;
    localparam logic [1:0] UNIT_WORD = 2'd2;
    localparam logic [1:0] UNIT_BAD  = 2'd3;

    logic                    req;
    logic [1:0]              unit;
    logic                    led_hit;
    logic                    ext_hit;
    logic                    hit_rw;
    logic [DEVICE_COUNT-1:0] sel;
    logic                    ok;
    logic                    need_old;

    logic [31:0] old_word;
    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] merged;
    logic [31:0] rd_val;
    logic [4:0]  byte_sh;

    logic [7:0]  led_d;
    logic [7:0]  led_q;

    // Address decode and access checks; LED window wins over any external slot.
    always_comb begin
        req      = re | we;
        unit     = we ? wd_unit : rd_unit;
        led_hit  = (addr >= LED_BASE) && (addr <= LED_BASE + 32'd3);
        ext_hit  = 1'b0;
        hit_rw   = 1'b0;
        sel      = '0;
        if (!led_hit) begin
            for (int i = 0; i < DEVICE_COUNT; i++) begin
                if (!ext_hit && (addr >= dev_addr_start[i]) && (addr <= dev_addr_end[i])) begin
                    ext_hit = 1'b1;
                    sel[i]  = 1'b1;
                    hit_rw  = dev_rw[i];
                end
            end
        end else begin
            hit_rw = 1'b1;
        end
        addr_misaligned = req && (((unit == UNIT_HALF) && addr[0]) ||
                                  ((unit == UNIT_WORD) && (addr[1:0] != 2'b00)));
        access_fault    = req && (!(led_hit || ext_hit) || (unit == UNIT_BAD) ||
                                  (we && !hit_rw));
        ok              = req && !access_fault && !addr_misaligned;
        // A full-word store is the only access that does not need the old word.
        need_old        = !we || (unit != UNIT_WORD);
    end

    always_comb begin
        for (int i = 0; i < DEVICE_COUNT; i++) begin
            dev_addr[i] = '0;
            dev_re[i]   = 1'b0;
            dev_we[i]   = 1'b0;
            if (ok && sel[i]) begin
                dev_addr[i] = 30'((addr - dev_addr_start[i]) >> 2);
                dev_re[i]   = need_old;
                dev_we[i]   = we;
            end
        end
    end

    // Data path: lane extraction for reads, lane merge for sub-word stores.
    always_comb begin
        old_word = led_hit ? {24'b0, led_q} : 32'b0;
        for (int i = 0; i < DEVICE_COUNT; i++) begin
            if (sel[i]) begin
                old_word = old_word | dev_rd[i];
            end
        end
        byte_sh   = {addr[1:0], 3'b000};
        shifted   = old_word >> byte_sh;
        lane_mask = 32'hFFFF_FFFF;
        rd_val    = shifted;
        merged    = wd;
        case (unit)
            UNIT_BYTE: begin
                lane_mask = 32'h0000_00FF << byte_sh;
                rd_val    = {24'b0, shifted[7:0]};
                merged    = (old_word & ~lane_mask) | ({24'b0, wd[7:0]} << byte_sh);
            end
            UNIT_HALF: begin
                lane_mask = 32'h0000_FFFF << byte_sh;
                rd_val    = {16'b0, shifted[15:0]};
                merged    = (old_word & ~lane_mask) | ({16'b0, wd[15:0]} << byte_sh);
            end
            default: begin
                lane_mask = 32'hFFFF_FFFF;
            end
        endcase
        rd = (ok && re) ? rd_val : 32'b0;
        for (int i = 0; i < DEVICE_COUNT; i++) begin
            dev_wd[i] = (ok && we && sel[i]) ? merged : 32'b0;
        end
        led_d = (ok && we && led_hit) ? merged[7:0] : led_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q <= 8'h00;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_mmio_bus.sv
// Bench for mmio_bus: directed map/alignment/RMW/LED steps, then randomized
// accesses checked against a byte-level reference model.
module tb_mmio_bus;

    localparam int          N        = 6;
    localparam logic [31:0] LED_BASE = 32'hA000_0000;

    logic        clk;
    logic        reset;
    logic        re;
    logic        we;
    logic [1:0]  rd_unit;
    logic [1:0]  wd_unit;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        access_fault;
    logic        addr_misaligned;
    logic [7:0]  led;
    logic [31:0] dev_addr_start [N];
    logic [31:0] dev_addr_end   [N];
    logic        dev_rw         [N];
    logic [29:0] dev_addr       [N];
    logic        dev_re         [N];
    logic [31:0] dev_rd         [N];
    logic        dev_we         [N];
    logic [31:0] dev_wd         [N];

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_rd;
    logic        exp_fault;
    logic        exp_mis;
    logic        exp_re   [N];
    logic        exp_we   [N];
    logic [29:0] exp_addr [N];
    logic [31:0] exp_wd   [N];
    logic [7:0]  led_model;
    logic [7:0]  led_next;

    mmio_bus #(.DEVICE_COUNT(N), .LED_BASE(LED_BASE)) dut (
        .clk(clk),
        .reset(reset),
        .re(re),
        .we(we),
        .rd_unit(rd_unit),
        .wd_unit(wd_unit),
        .addr(addr),
        .wd(wd),
        .rd(rd),
        .access_fault(access_fault),
        .addr_misaligned(addr_misaligned),
        .led(led),
        .dev_addr_start(dev_addr_start),
        .dev_addr_end(dev_addr_end),
        .dev_rw(dev_rw),
        .dev_addr(dev_addr),
        .dev_re(dev_re),
        .dev_rd(dev_rd),
        .dev_we(dev_we),
        .dev_wd(dev_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: works on byte lanes of the addressed word.
    task automatic model();
        int          hit;
        int          unit_n;
        int          nbytes;
        int          off;
        bit          in_led;
        bit          writable;
        logic [7:0]  old_b [4];
        logic [7:0]  new_b [4];
        logic [31:0] word;
        logic [31:0] merged;
        exp_rd    = '0;
        exp_fault = 1'b0;
        exp_mis   = 1'b0;
        led_next  = led_model;
        for (int i = 0; i < N; i++) begin
            exp_re[i]   = 1'b0;
            exp_we[i]   = 1'b0;
            exp_addr[i] = '0;
            exp_wd[i]   = '0;
        end
        if (!re && !we) return;
        unit_n = we ? int'(wd_unit) : int'(rd_unit);
        in_led = (addr >= LED_BASE) && (addr <= LED_BASE + 32'd3);
        hit = -1;
        if (!in_led) begin
            for (int i = 0; i < N; i++) begin
                if (hit < 0 && addr >= dev_addr_start[i] && addr <= dev_addr_end[i]) hit = i;
            end
        end
        writable  = in_led ? 1'b1 : (hit >= 0 ? bit'(dev_rw[hit]) : 1'b0);
        exp_mis   = (unit_n == 1 && addr % 2 != 0) || (unit_n == 2 && addr % 4 != 0);
        exp_fault = (!in_led && hit < 0) || unit_n == 3 || (we && !writable);
        if (exp_fault || exp_mis) return;
        word   = in_led ? {24'h0, led_model} : dev_rd[hit];
        nbytes = 1 << unit_n;
        off    = int'(addr % 4);
        for (int b = 0; b < 4; b++) begin
            old_b[b] = word[8*b +: 8];
            new_b[b] = old_b[b];
        end
        for (int b = 0; b < nbytes; b++) new_b[off + b] = wd[8*b +: 8];
        merged = {new_b[3], new_b[2], new_b[1], new_b[0]};
        if (re) begin
            for (int b = 0; b < nbytes; b++) exp_rd[8*b +: 8] = old_b[off + b];
        end
        if (in_led) begin
            if (we) led_next = merged[7:0];
        end else begin
            exp_addr[hit] = 30'((addr - dev_addr_start[hit]) / 4);
            exp_re[hit]   = !we || nbytes < 4;
            if (we) begin
                exp_we[hit] = 1'b1;
                exp_wd[hit] = merged;
            end
        end
    endtask

    task automatic check_comb(input string tag);
        model();
        chk({tag, ".rd"}, rd, exp_rd);
        chk({tag, ".fault"}, 32'(access_fault), 32'(exp_fault));
        chk({tag, ".misaligned"}, 32'(addr_misaligned), 32'(exp_mis));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s.dev_re%0d", tag, i), 32'(dev_re[i]), 32'(exp_re[i]));
            chk($sformatf("%s.dev_we%0d", tag, i), 32'(dev_we[i]), 32'(exp_we[i]));
            chk($sformatf("%s.dev_addr%0d", tag, i), 32'(dev_addr[i]), 32'(exp_addr[i]));
            chk($sformatf("%s.dev_wd%0d", tag, i), dev_wd[i], exp_wd[i]);
        end
    endtask

    // Drive one access mid-cycle, check combinational outputs, then the LED after the edge.
    task automatic step(input string tag, input logic r, input logic w, input logic [1:0] ru,
                        input logic [1:0] wu, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        re = r; we = w; rd_unit = ru; wd_unit = wu; addr = a; wd = d;
        #1;
        check_comb(tag);
        @(posedge clk);
        #1;
        led_model = led_next;
        chk({tag, ".led"}, 32'(led), 32'(led_model));
    endtask

    initial begin
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] a;
        int          k;
        int          mode;

        dev_addr_start[0] = 32'h8000_0000; dev_addr_end[0] = 32'h8000_7FFF; dev_rw[0] = 1'b0;
        dev_addr_start[1] = 32'h4000_0000; dev_addr_end[1] = 32'h4001_FFFF; dev_rw[1] = 1'b1;
        dev_addr_start[2] = 32'h0200_BFF8; dev_addr_end[2] = 32'h0200_BFFF; dev_rw[2] = 1'b1;
        dev_addr_start[3] = 32'h0200_4000; dev_addr_end[3] = 32'h0200_4007; dev_rw[3] = 1'b1;
        dev_addr_start[4] = 32'h1000_0000; dev_addr_end[4] = 32'h1000_00FF; dev_rw[4] = 1'b1;
        // Slot 5 overlaps the start of RAM; RAM (lower index) must win there.
        dev_addr_start[5] = 32'h3FFF_FF00; dev_addr_end[5] = 32'h4000_00FF; dev_rw[5] = 1'b0;
        for (int i = 0; i < N; i++) dev_rd[i] = 32'h0100_0000 * (i + 1);

        reset = 1'b0; re = 1'b0; we = 1'b0; rd_unit = 2'd0; wd_unit = 2'd0;
        addr = '0; wd = '0; led_model = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.led", 32'(led), 32'h0);
        check_comb("reset.idle");
        @(negedge clk);
        reset = 1'b1;

        step("led_wr", 1'b0, 1'b1, 2'd0, 2'd2, LED_BASE, 32'h0000_00A5);
        chk("led_wr.value", 32'(led), 32'hA5);
        step("led_rd", 1'b1, 1'b0, 2'd2, 2'd0, LED_BASE, 32'h0);
        chk("led_rd.value", rd, 32'h0000_00A5);

        // Asynchronous reset mid-cycle, with a write attempt held during it.
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("async_reset.led", 32'(led), 32'h0);
        we = 1'b1; wd_unit = 2'd2; addr = LED_BASE; wd = 32'h5A;
        @(posedge clk);
        #1 chk("reset_hold.led", 32'(led), 32'h0);
        @(negedge clk);
        we = 1'b0; reset = 1'b1; led_model = 8'h00;

        step("rom_rd", 1'b1, 1'b0, 2'd2, 2'd0, 32'h8000_0010, 32'h0);
        chk("rom_rd.re0", 32'(dev_re[0]), 32'h1);
        chk("rom_rd.idx", 32'(dev_addr[0]), 32'h4);
        step("ram_top", 1'b1, 1'b0, 2'd2, 2'd0, 32'h4001_FFFC, 32'h0);
        chk("ram_top.idx", 32'(dev_addr[1]), 32'h7FFF);
        step("ram_past", 1'b1, 1'b0, 2'd2, 2'd0, 32'h4002_0000, 32'h0);
        chk("ram_past.fault", 32'(access_fault), 32'h1);
        step("rom_wr", 1'b0, 1'b1, 2'd0, 2'd2, 32'h8000_0000, 32'h1234_5678);
        chk("rom_wr.fault", 32'(access_fault), 32'h1);
        chk("rom_wr.we0", 32'(dev_we[0]), 32'h0);
        step("half_mis", 1'b1, 1'b0, 2'd1, 2'd0, 32'h4000_0001, 32'h0);
        chk("half_mis.flag", 32'(addr_misaligned), 32'h1);
        step("word_mis", 1'b1, 1'b0, 2'd2, 2'd0, 32'h4000_0002, 32'h0);
        chk("word_mis.flag", 32'(addr_misaligned), 32'h1);
        step("byte_ok", 1'b1, 1'b0, 2'd0, 2'd0, 32'h4000_0003, 32'h0);
        chk("byte_ok.flags", {30'b0, access_fault, addr_misaligned}, 32'h0);

        dev_rd[1] = 32'h1122_3344;
        step("rmw_byte", 1'b0, 1'b1, 2'd0, 2'd0, 32'h4000_0002, 32'h0000_00EE);
        chk("rmw_byte.wd", dev_wd[1], 32'h11EE_3344);
        step("rmw_half", 1'b0, 1'b1, 2'd0, 2'd1, 32'h4000_0000, 32'h0000_BEEF);
        chk("rmw_half.wd", dev_wd[1], 32'h1122_BEEF);

        dev_rd[1] = 32'h8899_AABB;
        step("rd_byte3", 1'b1, 1'b0, 2'd0, 2'd0, 32'h4000_0003, 32'h0);
        chk("rd_byte3.rd", rd, 32'h0000_0088);
        step("rd_half2", 1'b1, 1'b0, 2'd1, 2'd0, 32'h4000_0002, 32'h0);
        chk("rd_half2.rd", rd, 32'h0000_8899);
        step("rd_bad", 1'b1, 1'b0, 2'd3, 2'd0, 32'h4000_0000, 32'h0);
        chk("rd_bad.fault", 32'(access_fault), 32'h1);

        step("led_b1", 1'b0, 1'b1, 2'd0, 2'd0, LED_BASE + 32'd1, 32'h0000_0077);
        step("led_h0", 1'b0, 1'b1, 2'd0, 2'd1, LED_BASE, 32'h0000_1C3E);
        chk("led_h0.value", 32'(led), 32'h3E);
        step("overlap", 1'b1, 1'b0, 2'd2, 2'd0, 32'h4000_0010, 32'h0);
        step("slot5", 1'b1, 1'b0, 2'd2, 2'd0, 32'h3FFF_FF80, 32'h0);
        step("both", 1'b1, 1'b1, 2'd2, 2'd0, 32'h4000_0001, 32'h0000_0099);
        step("idle", 1'b0, 1'b0, 2'd2, 2'd2, 32'h4000_0000, 32'h0);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) dev_rd[i] = $urandom;
            k = $urandom_range(0, N + 1);
            if (k == N) begin
                lo = LED_BASE; hi = LED_BASE + 32'd3;
            end else if (k < N) begin
                lo = dev_addr_start[k]; hi = dev_addr_end[k];
            end else begin
                lo = $urandom; hi = lo;
            end
            if ($urandom_range(0, 1) == 1) a = lo - 32'd8 + 32'($urandom_range(0, 15));
            else a = hi - 32'd7 + 32'($urandom_range(0, 15));
            mode = $urandom_range(0, 9);
            step($sformatf("rnd%0d", n), mode == 1 || (mode >= 2 && mode <= 5),
                 mode == 1 || mode >= 6, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 a, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_bus.md
Name: mmio_bus

Overview:
- Memory-mapped I/O interconnect between the cpu data/instruction port and its peripherals.
- Decodes a byte address against per-device inclusive address windows and checks unit alignment.
- Converts byte/halfword/word accesses into word accesses on the selected device, using read-modify-write for sub-word stores.
- Integrates the board LED register (former led_mmap) as a fixed internal slot; all other devices (rom, ram, mtime, mtimecmp, test bus) are external.

Parameters:
- DEVICE_COUNT, 6, number of external device slots.
- LED_BASE, 32'hA000_0000, byte base of the internal 4-byte LED window; LED_BASE[1:0] must be 0.

Ports:
- clk  in  1  system clock; LED register is rising-edge.
- reset  in  1  asynchronous, active-low; clears the LED register.
- re  in  1  cpu read request.
- we  in  1  cpu write request.
- rd_unit  in  2  read size: 0 byte, 1 halfword, 2 word, 3 illegal.
- wd_unit  in  2  write size, same encoding as rd_unit.
- addr  in  32  byte address.
- wd  in  32  write data, right-aligned.
- rd  out  32  read data, right-aligned, zero-extended; sign extension is done by the cpu.
- access_fault  out  1  unmapped address, write to a read-only device, or illegal unit.
- addr_misaligned  out  1  access not naturally aligned.
- led  out  8  LED register.
- dev_addr_start[DEVICE_COUNT]  in  32 each  inclusive window start, 4-byte aligned.
- dev_addr_end[DEVICE_COUNT]  in  32 each  inclusive window end.
- dev_rw[DEVICE_COUNT]  in  1 each  1 = writable, 0 = read-only.
- dev_addr[DEVICE_COUNT]  out  30 each  word index relative to window start, (addr - start)[31:2].
- dev_re[DEVICE_COUNT]  out  1 each  device read enable.
- dev_rd[DEVICE_COUNT]  in  32 each  device read word; must be combinational from dev_addr/dev_re.
- dev_we[DEVICE_COUNT]  out  1 each  device write enable, sampled by the device at the clk edge.
- dev_wd[DEVICE_COUNT]  out  32 each  full merged word to write.

Behaviour:
- Decode and data paths are fully combinational; the only state is the 8-bit LED register.
- Active unit: rd_unit when re=1, wd_unit when we=1. re and we together is a cpu error; the write path takes precedence for decode, but rd is still driven.
- Hit: start <= addr <= end, unsigned. The internal LED window is LED_BASE..LED_BASE+3 and is checked first. Among external devices, the lowest index wins on overlap.
- addr_misaligned = (re|we) and (halfword with addr[0]=1, or word with addr[1:0]!=0).
- access_fault = (re|we) and (no hit, or illegal unit, or we with dev_rw=0 on the hit device).
- The LED slot is always writable.
- Either flag set: all dev_re/dev_we = 0, rd = 0, LED unchanged.
- No request (re=0, we=0): all enables 0, rd = 0, flags 0.
- Unselected devices: re/we = 0, dev_addr/dev_wd = 0.
- Read: dev_re = 1 for the hit device. rd = word >> (8*addr[1:0]), masked to 8/16/32 bits per unit.
- Word write: dev_we = 1, dev_wd = wd, dev_re = 0.
- Sub-word write: dev_re = 1 and dev_we = 1. dev_wd = dev_rd with the addressed byte or halfword lane replaced by wd[7:0] or wd[15:0]; other lanes are preserved.
- LED read returns {24'b0, led}.
- LED write updates led on the clk edge with bits [7:0] of the merged word, so any store that covers byte 0 updates led. Byte stores to LED_BASE+1..3 leave led unchanged.
- reset low: led = 0 immediately, holds while low; writes are ignored while reset is low.
- Outputs during reset: led = 0; combinational outputs keep tracking their inputs.

Test Plan:
- Reset: drive reset low mid-cycle -> led = 0 immediately; release, word write 0xA5 to 0xA000_0000 -> led = 0xA5 after the next edge; reading it back gives rd = 0x0000_00A5.
- Range decode, map ROM 0x8000_0000–0x8000_7FFF (ro), RAM 0x4000_0000–0x4001_FFFF:
  - read 0x8000_0010 -> dev_re[0] = 1, dev_addr[0] = 4;
  - read 0x4001_FFFC -> RAM word index 0x7FFF;
  - read 0x4002_0000 -> access_fault = 1, no enables.
- Read-only device: word write to 0x8000_0000 -> access_fault = 1, dev_we[0] = 0.
- Alignment:
  - halfword read at 0x4000_0001 -> addr_misaligned = 1;
  - word read at 0x4000_0002 -> addr_misaligned = 1;
  - byte read at 0x4000_0003 -> no fault.
- Sub-word RMW: RAM word = 0x1122_3344.
  - byte write 0xEE at offset 2 -> dev_wd = 0x11EE_3344;
  - halfword write 0xBEEF at offset 0 -> dev_wd = 0x1122_BEEF.
- Sub-word read: RAM word = 0x8899_AABB.
  - byte read at offset 3 -> rd = 0x0000_0088;
  - halfword read at offset 2 -> rd = 0x0000_8899;
  - rd_unit = 3 -> access_fault = 1.
